// File: rtl/sd_boot_loader_if.sv
// rtl/sd_boot_loader_if.sv - SD card controller register bus between loader and card block
interface sd_boot_loader_if;
    logic       sd_cs_o;
    logic       sd_rw_n_o;
    logic [7:0] sd_addr_o;
    logic [7:0] sd_wdata_o;
    logic [7:0] sd_rdata_i;

    modport master (
        output sd_cs_o, sd_rw_n_o, sd_addr_o, sd_wdata_o,
        input  sd_rdata_i
    );

    modport slave (
        input  sd_cs_o, sd_rw_n_o, sd_addr_o, sd_wdata_o,
        output sd_rdata_i
    );
endinterface

// File: rtl/sd_boot_loader.sv
// rtl/sd_boot_loader.sv - copies consecutive 512-byte SD sectors into RAM through the SD register bus
module sd_boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter int unsigned GUARD_CYCLES   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      sector_base_i,
    input  logic [7:0]       sector_count_i,
    input  logic [15:0]      dest_addr_i,
    sd_boot_loader_if.master sd,
    output logic             mem_we_o,
    output logic [15:0]      mem_addr_o,
    output logic [7:0]       mem_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);
    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, SET_ADDR, START, GUARD, POLL,
        SET_PAGE, RD_ISSUE, RD_CAPTURE, NEXT, DONE, ERROR
    } state_e;

    localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);

    state_e      state_q;
    logic [31:0] sector_q;
    logic [7:0]  count_q;
    logic [15:0] dest_q;
    logic [23:0] tmo_q;
    logic [7:0]  guard_q;
    logic [1:0]  page_q;
    logic        ph_q;
    logic        cs_q;
    logic        rw_n_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_data_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [1:0]  nxt_byte;

    // During SET_ADDR the low bits of the register address double as the sector byte index.
    assign nxt_byte = addr_q[1:0] + 2'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sector_q   <= '0;
            count_q    <= '0;
            dest_q     <= '0;
            tmo_q      <= '0;
            guard_q    <= '0;
            page_q     <= '0;
            ph_q       <= 1'b0;
            cs_q       <= 1'b0;
            rw_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        sector_q <= sector_base_i;
                        count_q  <= sector_count_i;
                        dest_q   <= dest_addr_i;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        tmo_q    <= '0;
                        ph_q     <= 1'b0;
                        cs_q     <= (sector_count_i != 8'd0);
                        rw_n_q   <= 1'b1;
                        addr_q   <= 8'h04;
                        state_q  <= WAIT_RDY;
                    end
                end
                WAIT_RDY, POLL: begin
                    // ph_q=1 marks the second cycle of a busy-register read, when read data is valid.
                    if (count_q == 8'd0) begin
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (ph_q && !sd.sd_rdata_i[0]) begin
                        rw_n_q <= 1'b0;
                        if (state_q == WAIT_RDY) begin
                            addr_q  <= 8'h00;
                            wdata_q <= sector_q[7:0];
                            state_q <= SET_ADDR;
                        end else begin
                            addr_q  <= 8'h07;
                            wdata_q <= 8'h00;
                            page_q  <= 2'd0;
                            state_q <= SET_PAGE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                        ph_q  <= ~ph_q;
                    end
                end
                SET_ADDR: begin
                    if (addr_q[1:0] == 2'd3) begin
                        addr_q  <= 8'h05;
                        wdata_q <= 8'h00;
                        state_q <= START;
                    end else begin
                        addr_q  <= addr_q + 8'd1;
                        wdata_q <= sector_q[{nxt_byte, 3'b000} +: 8];
                    end
                end
                START: begin
                    rw_n_q  <= 1'b1;
                    guard_q <= '0;
                    if (GUARD_CYCLES == 0) begin
                        addr_q  <= 8'h04;
                        tmo_q   <= '0;
                        ph_q    <= 1'b0;
                        state_q <= POLL;
                    end else begin
                        cs_q    <= 1'b0;
                        state_q <= GUARD;
                    end
                end
                GUARD: begin
                    if (guard_q == GUARD_LAST) begin
                        cs_q    <= 1'b1;
                        addr_q  <= 8'h04;
                        tmo_q   <= '0;
                        ph_q    <= 1'b0;
                        state_q <= POLL;
                    end else begin
                        guard_q <= guard_q + 8'd1;
                    end
                end
                SET_PAGE: begin
                    rw_n_q  <= 1'b1;
                    addr_q  <= 8'h80;
                    state_q <= RD_ISSUE;
                end
                RD_ISSUE: state_q <= RD_CAPTURE;
                RD_CAPTURE: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= dest_q;
                    mem_data_q <= sd.sd_rdata_i;
                    dest_q     <= dest_q + 16'd1;
                    if (addr_q[6:0] != 7'h7F) begin
                        addr_q  <= addr_q + 8'd1;
                        state_q <= RD_ISSUE;
                    end else if (page_q != 2'd3) begin
                        page_q  <= page_q + 2'd1;
                        rw_n_q  <= 1'b0;
                        addr_q  <= 8'h07;
                        wdata_q <= {6'd0, page_q + 2'd1};
                        state_q <= SET_PAGE;
                    end else begin
                        cs_q    <= 1'b0;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    sector_q <= sector_q + 32'd1;
                    count_q  <= count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cs_q    <= 1'b1;
                        rw_n_q  <= 1'b1;
                        addr_q  <= 8'h04;
                        tmo_q   <= '0;
                        ph_q    <= 1'b0;
                        state_q <= WAIT_RDY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd.sd_cs_o    = cs_q;
    assign sd.sd_rw_n_o  = rw_n_q;
    assign sd.sd_addr_o  = addr_q;
    assign sd.sd_wdata_o = wdata_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
endmodule

// File: tb/tb_sd_boot_loader.sv
// tb/tb_sd_boot_loader.sv - self-checking bench for sd_boot_loader with an SD card model and RAM scoreboard
module tb_sd_boot_loader;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] sector_base_i;
    logic [7:0]  sector_count_i;
    logic [15:0] dest_addr_i;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    sd_boot_loader_if sd_bus ();

    sd_boot_loader #(.TIMEOUT_CYCLES(100), .GUARD_CYCLES(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .sector_base_i (sector_base_i),
        .sector_count_i(sector_count_i),
        .dest_addr_i   (dest_addr_i),
        .sd            (sd_bus),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  cnt;
        logic [15:0] dest;
        int          mode;
        int          wait_b;
        int          poll_b;
        int          mid_start;
        bit          exp_done;
        bit          exp_err;
        int          exp_nram;
        int          exp_nregw;
        int          exp_cs;
        int          exp_fin;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // card model state: busy_cnt <0 means busy forever
    logic [7:0]  m_sec [4];
    logic [1:0]  m_page;
    int          busy_cnt;
    int          poll_b_cfg;
    bit          poll_rand;
    int          data_mode;
    logic [15:0] regw_log [$];
    logic [23:0] ram_log [$];
    logic [15:0] exp_regw [$];
    logic [23:0] exp_ram [$];
    int          cs_cycles;
    int          gap_bad;
    int          cyc;
    int          last_we_cyc;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] buf_byte(input int mode, input logic [31:0] sec, input int idx);
        if (mode == 0) return 8'(idx);
        return 8'(sec[7:0] * 8'd29) ^ sec[31:24] ^ sec[15:8] ^ 8'(idx * 7 + 3);
    endfunction

    // SD card model: read data appears one cycle after the address was presented
    initial begin : card_model
        logic [7:0]  resp;
        logic [7:0]  rd_pend;
        logic [31:0] msec;
        rd_pend = 8'h00;
        sd_bus.sd_rdata_i = 8'h00;
        cyc = 0;
        last_we_cyc = 0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            resp = 8'($urandom);
            if (sd_bus.sd_cs_o && sd_bus.sd_rw_n_o) begin
                msec = {m_sec[3], m_sec[2], m_sec[1], m_sec[0]};
                if (sd_bus.sd_addr_o == 8'h04) begin
                    resp = {7'($urandom), busy_cnt != 0};
                    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
                end else if (sd_bus.sd_addr_o[7]) begin
                    resp = buf_byte(data_mode, msec, int'(m_page) * 128 + int'(sd_bus.sd_addr_o[6:0]));
                end
            end
            sd_bus.sd_rdata_i = rd_pend;
            rd_pend = resp;
            if (sd_bus.sd_cs_o) cs_cycles = cs_cycles + 1;
            if (sd_bus.sd_cs_o && !sd_bus.sd_rw_n_o) begin
                regw_log.push_back({sd_bus.sd_addr_o, sd_bus.sd_wdata_o});
                if (sd_bus.sd_addr_o < 8'h04) m_sec[sd_bus.sd_addr_o[1:0]] = sd_bus.sd_wdata_o;
                if (sd_bus.sd_addr_o == 8'h05) busy_cnt = poll_rand ? int'($urandom_range(30, 0)) : poll_b_cfg;
                if (sd_bus.sd_addr_o == 8'h07) m_page = sd_bus.sd_wdata_o[1:0];
            end
            if (mem_we_o) begin
                if ((ram_log.size() % 128) != 0 && (cyc - last_we_cyc) != 2) gap_bad = gap_bad + 1;
                last_we_cyc = cyc;
                ram_log.push_back({mem_addr_o, mem_data_o});
            end
        end
    end

    task automatic check_reset_state(input string nm);
        check({nm, " busy_o"}, busy_o, 0);
        check({nm, " done_o"}, done_o, 0);
        check({nm, " error_o"}, error_o, 0);
        check({nm, " sd_cs_o"}, sd_bus.sd_cs_o, 0);
        check({nm, " sd_rw_n_o"}, sd_bus.sd_rw_n_o, 1);
        check({nm, " sd_addr_o"}, sd_bus.sd_addr_o, 0);
        check({nm, " sd_wdata_o"}, sd_bus.sd_wdata_o, 0);
        check({nm, " mem_we_o"}, mem_we_o, 0);
        check({nm, " mem_addr_o"}, mem_addr_o, 0);
        check({nm, " mem_data_o"}, mem_data_o, 0);
    endtask

    task automatic do_start(input vec_t v, input string nm);
        logic [31:0] sec;
        regw_log.delete();
        ram_log.delete();
        exp_regw.delete();
        exp_ram.delete();
        cs_cycles   = 0;
        gap_bad     = 0;
        data_mode   = v.mode;
        busy_cnt    = v.wait_b;
        poll_b_cfg  = v.poll_b;
        poll_rand   = (v.poll_b == -2);
        for (int s = 0; s < int'(v.cnt); s++) begin
            sec = v.base + 32'(s);
            for (int b = 0; b < 4; b++) exp_regw.push_back({8'(b), sec[8*b +: 8]});
            exp_regw.push_back(16'h0500);
            for (int p = 0; p < 4; p++) exp_regw.push_back({8'h07, 8'(p)});
            for (int i = 0; i < 512; i++)
                exp_ram.push_back({16'(int'(v.dest) + s * 512 + i), buf_byte(v.mode, sec, i)});
        end
        @(negedge clk);
        sector_base_i  = v.base;
        sector_count_i = v.cnt;
        dest_addr_i    = v.dest;
        start_i        = 1'b1;
        @(negedge clk);
        start_i        = 1'b0;
        sector_base_i  = $urandom;
        sector_count_i = 8'($urandom);
        dest_addr_i    = 16'($urandom);
        check({nm, " busy after start"}, busy_o, 1);
        check({nm, " done cleared"}, done_o, 0);
        check({nm, " error cleared"}, error_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int k;
        int limit;
        int mism;
        bit fin;
        bit pulsed;
        do_start(v, nm);
        k      = 1;
        limit  = 2300 * (int'(v.cnt) + 1);
        pulsed = 1'b0;
        fin    = done_o || error_o;
        while (!fin && k < limit) begin
            @(negedge clk);
            k++;
            start_i = 1'b0;
            if (v.mid_start != 0 && !pulsed && ram_log.size() >= 200) begin
                sector_base_i  = 32'hDEAD_0000;
                sector_count_i = 8'd5;
                dest_addr_i    = 16'h5555;
                start_i        = 1'b1;
                pulsed         = 1'b1;
            end
            fin = done_o || error_o;
        end
        start_i = 1'b0;
        check({nm, " finished in budget"}, fin, 1);
        check({nm, " mid start pulsed"}, pulsed, v.mid_start);
        if (v.exp_fin >= 0) check({nm, " cycles to finish"}, k, v.exp_fin);
        check({nm, " busy_o at end"}, busy_o, 0);
        check({nm, " sd_cs_o at end"}, sd_bus.sd_cs_o, 0);
        repeat (3) @(negedge clk);
        check({nm, " done_o"}, done_o, v.exp_done);
        check({nm, " error_o"}, error_o, v.exp_err);
        check({nm, " reg write count"}, regw_log.size(), v.exp_nregw);
        check({nm, " ram write count"}, ram_log.size(), v.exp_nram);
        mism = 0;
        for (int i = 0; i < regw_log.size() && i < exp_regw.size(); i++)
            if (regw_log[i] != exp_regw[i]) mism++;
        check({nm, " reg write content"}, mism, 0);
        mism = 0;
        for (int i = 0; i < ram_log.size() && i < exp_ram.size(); i++)
            if (ram_log[i] != exp_ram[i]) mism++;
        check({nm, " ram write content"}, mism, 0);
        check({nm, " in-page byte spacing"}, gap_bad, 0);
        if (v.exp_cs >= 0) check({nm, " sd_cs_o cycles"}, cs_cycles, v.exp_cs);
    endtask

    initial begin : main
        vec_t vecs [7];
        vec_t v;
        int   k;
        int   n_ram;
        int   n_cs;
        //          base          cnt    dest      mode wait poll mid done err nram nregw cs    fin
        vecs[0] = '{32'h0000_0005, 8'd0, 16'h1234, 0,  0,   0,   0,  1,   0,  0,    0,   0,    2};
        vecs[1] = '{32'h0000_0010, 8'd1, 16'h2000, 0,  0,   0,   0,  1,   0,  512,  9,   1037, 1043};
        vecs[2] = '{32'h0000_0007, 8'd2, 16'hFF00, 0,  0,   0,   0,  1,   0,  1024, 18,  2074, 2085};
        vecs[3] = '{32'h0000_0020, 8'd1, 16'h0000, 0,  -1,  0,   0,  0,   1,  0,    0,   100,  101};
        vecs[4] = '{32'h0000_0030, 8'd1, 16'h0100, 0,  0,   -1,  0,  0,   1,  0,    5,   107,  112};
        vecs[5] = '{32'hFFFF_FFFF, 8'd2, 16'h8000, 1,  3,   5,   0,  1,   0,  1024, 18,  -1,   -1};
        vecs[6] = '{32'h0000_0100, 8'd1, 16'h4000, 1,  0,   0,   1,  1,   0,  512,  9,   1037, 1043};

        rst_i = 1'b1;
        start_i = 1'b0;
        sector_base_i = '0;
        sector_count_i = '0;
        dest_addr_i = '0;
        busy_cnt = 0;
        poll_b_cfg = 0;
        poll_rand = 1'b0;
        data_mode = 0;
        m_page = 2'd0;
        for (int i = 0; i < 4; i++) m_sec[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 4; r++) begin
            v.base      = $urandom;
            v.cnt       = 8'($urandom_range(2, 1));
            v.dest      = 16'($urandom);
            v.mode      = 1;
            v.wait_b    = int'($urandom_range(30, 0));
            v.poll_b    = -2;
            v.mid_start = 0;
            v.exp_done  = 1'b1;
            v.exp_err   = 1'b0;
            v.exp_nram  = 512 * int'(v.cnt);
            v.exp_nregw = 9 * int'(v.cnt);
            v.exp_cs    = -1;
            v.exp_fin   = -1;
            run_vec(v, $sformatf("rand%0d", r));
        end

        // reset while page 2 of the first sector is being copied
        do_start(vecs[2], "rstmid");
        k = 1;
        while (ram_log.size() < 300 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rstmid reached page 2", ram_log.size() >= 300, 1);
        check("rstmid model page", m_page, 2);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_state("rstmid");
        n_ram = ram_log.size();
        n_cs  = cs_cycles;
        repeat (50) @(negedge clk);
        check("rstmid no ram writes after reset", ram_log.size(), n_ram);
        check("rstmid no bus access after reset", cs_cycles, n_cs);
        check("rstmid stays idle", busy_o, 0);

        run_vec(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
